nonce_sweep_scheduler: RTL and testbench

- Sequences the double-SHA-256 mining loop over two SHA computational engines:
  - a 640-bit header engine (stage 1);
  - a 256-bit digest engine (stage 2).
- For each nonce in a programmed range, it:
  - builds the header;
  - runs stage 1, then feeds the stage-1 digest to stage 2;
  - compares the final hash against a target;
  - stops on the first hit or when the range is exhausted.
- Sits between the host register interface and the SHA engines.

---
 rtl/nonce_sweep_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_nonce_sweep_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweep_scheduler.sv
// Nonce sweep scheduler: drives the double-SHA-256 loop over two engines.
// For each nonce in [nonce_start .. nonce_end] (inclusive, wrapping mod 2^32)
// it builds the 640-bit header, runs stage 1, then stage 2 on the stage-1
// digest, and compares the final hash against the target. The sweep stops on
// the first hit or when the range is used up.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   start, stop           sweep start pulse / abort
//   header_prefix         header bits 639:32
//   nonce_start/_end      inclusive nonce range
//   target                hit when final hash < target (unsigned)
//   sha1_*                stage-1 engine handshake (640-bit message)
//   sha2_*                stage-2 engine handshake (256-bit message)
//   busy, found,
//   exhausted, error      status (terminal flags held until next start)
//   found_nonce/_hash     result of the hit
//   hashes_done           compares completed in this sweep
module nonce_sweep_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         stop,
  input  logic [607:0] header_prefix,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic [639:0] sha1_msg,
  output logic         sha1_begin,
  input  logic         sha1_done,
  input  logic [255:0] sha1_digest,
  output logic [255:0] sha2_msg,
  output logic         sha2_begin,
  input  logic         sha2_done,
  input  logic [255:0] sha2_digest,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         error,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  hashes_done
);

  localparam int unsigned PREFIX_W = 608;
  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned HASH_W   = 256;
  localparam int unsigned MSG1_W   = PREFIX_W + NONCE_W;
  localparam int unsigned WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
  // Counter value on the last waiting cycle before the watchdog fires.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_H1_START,
    S_H1_WAIT,
    S_H2_START,
    S_H2_WAIT,
    S_COMPARE,
    S_FOUND,
    S_EXHAUSTED,
    S_ERROR
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_accept;
  logic                 w_terminal;
  logic                 w_busy_state;
  logic                 w_next_busy;
  logic                 w_hit;
  logic                 w_last;
  logic                 w_wd_expire;
  logic [NONCE_W-1:0]   w_nonce_inc;

  logic [PREFIX_W-1:0]  r_prefix;
  logic [NONCE_W-1:0]   r_nonce_end;
  logic [HASH_W-1:0]    r_target;
  logic [NONCE_W-1:0]   r_nonce;
  logic [HASH_W-1:0]    r_hash;
  logic [WD_W-1:0]      r_wdog;
  logic [MSG1_W-1:0]    r_sha1_msg;
  logic                 r_sha1_begin;
  logic [HASH_W-1:0]    r_sha2_msg;
  logic                 r_sha2_begin;
  logic                 r_busy;
  logic                 r_found;
  logic                 r_exhausted;
  logic                 r_error;
  logic [NONCE_W-1:0]   r_found_nonce;
  logic [HASH_W-1:0]    r_found_hash;
  logic [NONCE_W-1:0]   r_hashes_done;

  // Decoded state classes and compare results
  assign w_terminal   = (r_state == S_FOUND) || (r_state == S_EXHAUSTED) || (r_state == S_ERROR);
  assign w_busy_state = (r_state == S_H1_START) || (r_state == S_H1_WAIT) ||
                        (r_state == S_H2_START) || (r_state == S_H2_WAIT) ||
                        (r_state == S_COMPARE);
  assign w_next_busy  = (w_next_state == S_H1_START) || (w_next_state == S_H1_WAIT) ||
                        (w_next_state == S_H2_START) || (w_next_state == S_H2_WAIT) ||
                        (w_next_state == S_COMPARE);
  assign w_hit        = (r_hash < r_target);
  assign w_last       = (r_nonce == r_nonce_end);
  assign w_wd_expire  = WD_EN && (r_wdog == WD_LAST);
  assign w_nonce_inc  = r_nonce + NONCE_W'(1);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; stop overrides everything, including a same-cycle start
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_H1_START: w_next_state = S_H1_WAIT;
      S_H1_WAIT: begin
        if (sha1_done) begin
          w_next_state = S_H2_START;
        end else if (w_wd_expire) begin
          w_next_state = S_ERROR;
        end
      end
      S_H2_START: w_next_state = S_H2_WAIT;
      S_H2_WAIT: begin
        if (sha2_done) begin
          w_next_state = S_COMPARE;
        end else if (w_wd_expire) begin
          w_next_state = S_ERROR;
        end
      end
      S_COMPARE: begin
        if (w_hit) begin
          w_next_state = S_FOUND;
        end else if (w_last) begin
          w_next_state = S_EXHAUSTED;
        end else begin
          w_next_state = S_H1_START;
        end
      end
      default: w_next_state = r_state;
    endcase
    if (stop) begin
      if (w_busy_state || w_terminal) begin
        w_next_state = S_IDLE;
      end
    end else if (start && ((r_state == S_IDLE) || w_terminal)) begin
      w_accept     = 1'b1;
      w_next_state = S_H1_START;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prefix      <= '0;
      r_nonce_end   <= '0;
      r_target      <= '0;
      r_nonce       <= '0;
      r_hash        <= '0;
      r_wdog        <= '0;
      r_sha1_msg    <= '0;
      r_sha1_begin  <= 1'b0;
      r_sha2_msg    <= '0;
      r_sha2_begin  <= 1'b0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
      r_error       <= 1'b0;
      r_found_nonce <= '0;
      r_found_hash  <= '0;
      r_hashes_done <= '0;
    end else begin
      // Begin pulses are high for exactly the cycle spent in the start states
      r_sha1_begin <= (w_next_state == S_H1_START);
      r_sha2_begin <= (w_next_state == S_H2_START);
      r_busy       <= w_next_busy;

      if (w_accept) begin
        r_prefix      <= header_prefix;
        r_nonce_end   <= nonce_end;
        r_target      <= target;
        r_nonce       <= nonce_start;
        r_sha1_msg    <= {header_prefix, nonce_start};
        r_found       <= 1'b0;
        r_exhausted   <= 1'b0;
        r_error       <= 1'b0;
        r_found_nonce <= '0;
        r_found_hash  <= '0;
        r_hashes_done <= '0;
      end else if (stop && w_terminal) begin
        r_found     <= 1'b0;
        r_exhausted <= 1'b0;
        r_error     <= 1'b0;
      end

      case (r_state)
        S_H1_START, S_H2_START: r_wdog <= '0;
        S_H1_WAIT: begin
          if (sha1_done) begin
            r_sha2_msg <= sha1_digest;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
            if (w_next_state == S_ERROR) begin
              r_error <= 1'b1;
            end
          end
        end
        S_H2_WAIT: begin
          if (sha2_done) begin
            r_hash <= sha2_digest;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
            if (w_next_state == S_ERROR) begin
              r_error <= 1'b1;
            end
          end
        end
        S_COMPARE: begin
          // An abort in this cycle discards the compare entirely
          if (!stop) begin
            r_hashes_done <= r_hashes_done + NONCE_W'(1);
            if (w_hit) begin
              r_found       <= 1'b1;
              r_found_nonce <= r_nonce;
              r_found_hash  <= r_hash;
            end else if (w_last) begin
              r_exhausted <= 1'b1;
            end else begin
              r_nonce    <= w_nonce_inc;
              r_sha1_msg <= {r_prefix, w_nonce_inc};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sha1_msg    = r_sha1_msg;
  assign sha1_begin  = r_sha1_begin;
  assign sha2_msg    = r_sha2_msg;
  assign sha2_begin  = r_sha2_begin;
  assign busy        = r_busy;
  assign found       = r_found;
  assign exhausted   = r_exhausted;
  assign error       = r_error;
  assign found_nonce = r_found_nonce;
  assign found_hash  = r_found_hash;
  assign hashes_done = r_hashes_done;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Self-checking bench for nonce_sweep_scheduler: table of directed sweeps,
// hand-written timing/abort/reset/watchdog sequences and randomized sweeps
// checked against a loop-level reference model.
module tb_nonce_sweep_scheduler;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start, stop;
  logic [607:0] header_prefix;
  logic [31:0]  nonce_start, nonce_end;
  logic [255:0] target;
  logic [639:0] sha1_msg;
  logic         sha1_begin, sha1_done;
  logic [255:0] sha1_digest;
  logic [255:0] sha2_msg;
  logic         sha2_begin, sha2_done;
  logic [255:0] sha2_digest;
  logic         busy, found, exhausted, error;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [31:0]  hashes_done;

  nonce_sweep_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stop(stop),
    .header_prefix(header_prefix), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .sha1_msg(sha1_msg), .sha1_begin(sha1_begin), .sha1_done(sha1_done),
    .sha1_digest(sha1_digest), .sha2_msg(sha2_msg), .sha2_begin(sha2_begin),
    .sha2_done(sha2_done), .sha2_digest(sha2_digest), .busy(busy), .found(found),
    .exhausted(exhausted), .error(error), .found_nonce(found_nonce),
    .found_hash(found_hash), .hashes_done(hashes_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Engine stub controls
  int           lat1 = 3, lat2 = 3;
  bit           hang1 = 0;
  int           mode = 0;          // 0 all-ones, 1 zero only for hit_n, 2 mixed
  logic [31:0]  hit_n = 0;
  logic         stub_d1 = 0, stub_d2 = 0, stray_d1 = 0, stray_d2 = 0;
  int           c1 = 0, c2 = 0;
  logic [639:0] m1;
  logic [255:0] m2;
  logic [607:0] pfx;

  assign sha1_done = stub_d1 | stray_d1;
  assign sha2_done = stub_d2 | stray_d2;

  function automatic logic [255:0] f1(input logic [639:0] msg);
    return {msg[639:416], msg[31:0]};
  endfunction

  function automatic logic [255:0] f2(input logic [255:0] d);
    logic [31:0] mix;
    mix = 32'(d[31:0] * 32'h9E3779B1);
    case (mode)
      0:       return {256{1'b1}};
      1:       return (d[31:0] == hit_n) ? 256'd0 : {256{1'b1}};
      default: return {mix, d[223:0]};
    endcase
  endfunction

  // Engine stubs: done pulses L cycles after begin, changes on negedge
  always @(negedge clk) begin
    stub_d1 = 1'b0;
    stub_d2 = 1'b0;
    if (!n_rst) begin
      c1 = 0;
      c2 = 0;
    end else begin
      if (c1 != 0) begin
        c1 = c1 - 1;
        if (c1 == 0 && !hang1) begin
          stub_d1 = 1'b1;
          sha1_digest = f1(m1);
        end
      end
      if (sha1_begin) begin
        c1 = lat1;
        m1 = sha1_msg;
      end
      if (c2 != 0) begin
        c2 = c2 - 1;
        if (c2 == 0) begin
          stub_d2 = 1'b1;
          sha2_digest = f2(m2);
        end
      end
      if (sha2_begin) begin
        c2 = lat2;
        m2 = sha2_msg;
      end
    end
  end

  // Record every stage-1 message issued
  logic [639:0] q[$];
  int nb1 = 0;
  always @(posedge clk) begin
    #1;
    if (sha1_begin) begin
      q.push_back(sha1_msg);
      nb1++;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic new_prefix();
    for (int i = 0; i < 19; i++) pfx[i*32 +: 32] = $urandom();
    header_prefix = pfx;
  endtask

  // Called at a negedge; starts a sweep and waits for a terminal flag
  task automatic run_sweep(input logic [31:0] ns, input logic [31:0] ne,
                           input logic [255:0] tgt, output bit ok);
    q.delete();
    new_prefix();
    nonce_start = ns;
    nonce_end   = ne;
    target      = tgt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (found || exhausted || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Stage-1 messages must be {prefix, ns+i} for i = 0 .. cnt-1
  task automatic chk_seq(input string nm, input logic [31:0] ns, input logic [31:0] cnt);
    bit good;
    good = (q.size() == int'(cnt));
    for (int i = 0; i < q.size(); i++) begin
      if (q[i][31:0] !== 32'(ns + 32'(i)) || q[i][639:32] !== pfx) good = 1'b0;
    end
    chk(nm, 256'(q.size()), good ? 256'(cnt) : ~256'(cnt));
  endtask

  // Reference: walk the range with plain arithmetic
  task automatic model(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt,
                       output bit ef, output bit ee, output logic [31:0] en,
                       output logic [255:0] eh, output logic [31:0] ecnt);
    logic [31:0]  n;
    logic [255:0] h;
    n = ns; ef = 0; ee = 0; en = 0; eh = 0; ecnt = 0;
    for (int i = 0; i < 100; i++) begin
      h = f2(f1({pfx, n}));
      ecnt++;
      if (h < tgt) begin
        ef = 1; en = n; eh = h;
        break;
      end
      if (n == ne) begin
        ee = 1;
        break;
      end
      n++;
    end
  endtask

  typedef struct {
    logic [31:0]  ns, ne;
    int           md;
    logic [31:0]  hn;
    logic [255:0] tgt;
    bit           efound, eexh;
    logic [31:0]  enonce;
    logic [255:0] ehash;
    logic [31:0]  ecnt;
  } vec_t;

  vec_t tv[7];

  initial begin
    bit ok, ef, ee;
    logic [31:0] en, ecnt, ns, ne, snap;
    logic [255:0] eh, tgt, s2;
    int b1c, b2c, fc;

    tv[0] = '{32'd5, 32'd5, 1, 32'd5, {256{1'b1}}, 1'b1, 1'b0, 32'd5, 256'd0, 32'd1};
    tv[1] = '{32'd10, 32'd13, 0, 32'd0, 256'd0, 1'b0, 1'b1, 32'd0, 256'd0, 32'd4};
    tv[2] = '{32'hFFFFFFFE, 32'd1, 0, 32'd0, 256'd0, 1'b0, 1'b1, 32'd0, 256'd0, 32'd4};
    tv[3] = '{32'd0, 32'd20, 1, 32'd7, 256'd1, 1'b1, 1'b0, 32'd7, 256'd0, 32'd8};
    tv[4] = '{32'd100, 32'd110, 1, 32'd110, 256'd1, 1'b1, 1'b0, 32'd110, 256'd0, 32'd11};
    tv[5] = '{32'd1, 32'd2, 0, 32'd0, {256{1'b1}}, 1'b0, 1'b1, 32'd0, 256'd0, 32'd2};
    tv[6] = '{32'd3, 32'd3, 0, 32'd0, 256'd0, 1'b0, 1'b1, 32'd0, 256'd0, 32'd1};

    n_rst = 1'b0; start = 1'b0; stop = 1'b0;
    header_prefix = '0; nonce_start = '0; nonce_end = '0; target = '0;
    sha1_digest = '0; sha2_digest = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", 256'({busy, found, exhausted, error, sha1_begin, sha2_begin}), 256'd0);
    chk("rst_msgs", 256'(sha1_msg[639:256] | 384'(sha1_msg[255:0])) | sha2_msg, 256'd0);
    chk("rst_res", found_hash | 256'(found_nonce) | 256'(hashes_done), 256'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Begin/found timing with L1 = L2 = 3, single nonce hit
    lat1 = 3; lat2 = 3; mode = 1; hit_n = 5;
    new_prefix();
    nonce_start = 5; nonce_end = 5; target = {256{1'b1}};
    start = 1'b1;
    b1c = -1; b2c = -1; fc = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (sha1_begin && b1c < 0) b1c = k;
      if (sha2_begin && b2c < 0) b2c = k;
      if (found && fc < 0) fc = k;
      if (k == 9) chk("t_busy9", 256'(busy), 256'd1);
      if (k == 10) chk("t_busy10", 256'(busy), 256'd0);
    end
    chk("t_sha1_begin_cyc", 256'(b1c), 256'd1);
    chk("t_sha2_begin_cyc", 256'(b2c), 256'd5);
    chk("t_found_cyc", 256'(fc), 256'd10);
    chk("t_found_nonce", 256'(found_nonce), 256'd5);
    chk("t_hashes", 256'(hashes_done), 256'd1);

    // stop + start together in FOUND: stop wins, flags cleared
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_flags", 256'({busy, found, exhausted, error, sha1_begin}), 256'd0);
    @(negedge clk);
    chk("ss_idle", 256'({busy, sha1_begin}), 256'd0);

    // Directed table
    foreach (tv[i]) begin
      mode = tv[i].md; hit_n = tv[i].hn;
      lat1 = 1 + i % 3; lat2 = 2 + i % 4;
      run_sweep(tv[i].ns, tv[i].ne, tv[i].tgt, ok);
      chk($sformatf("tv%0d_done", i), 256'(ok), 256'd1);
      chk($sformatf("tv%0d_flags", i), 256'({found, exhausted, error, busy}),
          256'({tv[i].efound, tv[i].eexh, 1'b0, 1'b0}));
      chk($sformatf("tv%0d_nonce", i), 256'(found_nonce), 256'(tv[i].enonce));
      chk($sformatf("tv%0d_hash", i), found_hash, tv[i].ehash);
      chk($sformatf("tv%0d_count", i), 256'(hashes_done), 256'(tv[i].ecnt));
      chk_seq($sformatf("tv%0d_seq", i), tv[i].ns, tv[i].ecnt);
    end

    // Watchdog: stage 1 never completes
    hang1 = 1; lat1 = 3; mode = 0;
    nonce_start = 9; nonce_end = 9; target = 0;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 17) chk("wd_pre", 256'({error, busy}), 256'b01);
      if (k == 18) chk("wd_fire", 256'({error, busy}), 256'b10);
    end
    hang1 = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wd_restart", 256'({error, busy}), 256'b01);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = exhausted | found | error;
    end
    chk("wd_recover", 256'({exhausted, error, hashes_done}), {222'd0, 1'b1, 1'b0, 32'd1});

    // stop during H2_WAIT; the late sha2_done must be ignored
    lat1 = 2; lat2 = 8; mode = 0;
    nonce_start = 40; nonce_end = 50; target = 0;
    start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 7) stop = 1'b1;
      if (k == 8) begin
        stop = 1'b0;
        chk("stop_idle", 256'(busy), 256'd0);
        snap = 32'(nb1);
      end
    end
    chk("stop_flags", 256'({found, exhausted, error, busy}), 256'd0);
    chk("stop_nobegin", 256'(nb1), 256'(snap));
    chk("stop_count", 256'(hashes_done), 256'd0);

    // Stray done pulses while idle change nothing
    s2 = sha2_msg;
    sha2_digest = 256'hDEAD;
    stray_d1 = 1'b1; stray_d2 = 1'b1;
    @(negedge clk);
    stray_d1 = 1'b0; stray_d2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_msg", sha2_msg, s2);
    chk("stray_state", 256'({busy, found, exhausted, error}), 256'd0);

    // Reset during H1_WAIT
    lat1 = 10; lat2 = 3;
    nonce_start = 77; nonce_end = 80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("arst_flags", 256'({busy, found, exhausted, error, sha1_begin, sha2_begin}), 256'd0);
    chk("arst_msg", 256'(sha1_msg[31:0]) | 256'(sha1_msg[639:608]) | sha2_msg, 256'd0);
    @(negedge clk);
    n_rst = 1'b1;
    snap = 32'(nb1);
    repeat (15) @(negedge clk);
    chk("arst_nobegin", 256'(nb1), 256'(snap));

    // Randomized sweeps against the reference model
    for (int it = 0; it < 20; it++) begin
      lat1 = $urandom_range(1, 6);
      lat2 = $urandom_range(1, 6);
      ns = (it % 4 == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 6)) : $urandom();
      ne = ns + 32'($urandom_range(0, 15));
      if (it % 3 == 0) begin
        mode = 1;
        hit_n = ns + 32'($urandom_range(0, 20));
        tgt = 256'd1;
      end else begin
        mode = 2;
        tgt = {32'($urandom_range(0, 32'h0C000000)), 224'd0};
      end
      run_sweep(ns, ne, tgt, ok);
      model(ns, ne, tgt, ef, ee, en, eh, ecnt);
      chk($sformatf("r%0d_done", it), 256'(ok), 256'd1);
      chk($sformatf("r%0d_flags", it), 256'({found, exhausted, error}), 256'({ef, ee, 1'b0}));
      chk($sformatf("r%0d_nonce", it), 256'(found_nonce), 256'(en));
      chk($sformatf("r%0d_hash", it), found_hash, eh);
      chk($sformatf("r%0d_count", it), 256'(hashes_done), 256'(ecnt));
      chk_seq($sformatf("r%0d_seq", it), ns, ecnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
